// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy flags, error pulses and selectable
// registered or first-word-fall-through read data.
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = MODE_STD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_bad_ae
    $error("param_sync_fifo: AE_THRESH must be below AF_THRESH");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_THRESH must not exceed DEPTH");
  end
  if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
    $error("param_sync_fifo: FWFT must be 0 or 1");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] head;

  // Flags come only from the registered count, so rd/wr never reach them.
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign almost_full  = (count >= CW'(AF_THRESH));

  // A write at full is still taken when a read frees a slot on the same edge.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr & ~wr_acc;
      underflow <= rd & ~rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    always_comb begin
      data_out = '0;
      if (!empty) data_out = head;
    end
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      data_out <= '0;
      else if (rd_acc) data_out <= head;
    end
  end

endmodule
